// File: rtl/mouse_init_sequencer.sv
// rtl/mouse_init_sequencer.sv - PS/2 mouse power-up/recovery sequencer
// Issues reset/enable commands, validates replies and gates packet streaming.
module mouse_init_sequencer #(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int MAX_RETRY   = 3,
    parameter int TO_W        = 26
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       restart_i,
    input  logic       tx_idle_i,
    input  logic       tx_done_tick_i,
    input  logic       rx_done_tick_i,
    input  logic [7:0] rx_data_i,
    output logic       wr_ps2_o,
    output logic [7:0] tx_data_o,
    output logic       stream_en_o,
    output logic       init_done_o,
    output logic       init_err_o,
    output logic [1:0] retries_o
);

    localparam logic [7:0] CMD_RST  = 8'hFF;
    localparam logic [7:0] CMD_EN   = 8'hF4;
    localparam logic [7:0] RX_ACK   = 8'hFA;
    localparam logic [7:0] RX_RSND  = 8'hFE;
    localparam logic [7:0] RX_BAT   = 8'hAA;
    localparam logic [7:0] RX_ID    = 8'h00;

    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]      RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [1:0]      FE_LAST   = 2'd3;

    typedef enum logic [3:0] {
        SEND_RST,
        WAIT_TX_RST,
        ACK_RST,
        BAT,
        ID,
        SEND_EN,
        WAIT_TX_EN,
        ACK_EN,
        STREAM,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic            wr_ps2_q, wr_ps2_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            stream_en_q, stream_en_d;
    logic            init_done_q, init_done_d;
    logic            init_err_q, init_err_d;
    logic [1:0]      retries_q, retries_d;
    logic [1:0]      fe_cnt_q, fe_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic counting;
    logic timeout_hit;
    logic fail;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEND_RST;
            wr_ps2_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            stream_en_q <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            retries_q   <= 2'd0;
            fe_cnt_q    <= 2'd0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ps2_q    <= wr_ps2_d;
            tx_data_q   <= tx_data_d;
            stream_en_q <= stream_en_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            retries_q   <= retries_d;
            fe_cnt_q    <= fe_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        counting = (state_q == WAIT_TX_RST) || (state_q == ACK_RST) ||
                   (state_q == BAT) || (state_q == ID) ||
                   (state_q == WAIT_TX_EN) || (state_q == ACK_EN);
        // A received byte always beats an expiring timeout on the same cycle.
        timeout_hit = counting && !rx_done_tick_i && (to_cnt_q == TO_LIMIT);
    end

    always_comb begin
        state_d   = state_q;
        wr_ps2_d  = 1'b0;
        tx_data_d = tx_data_q;
        retries_d = retries_q;
        fe_cnt_d  = fe_cnt_q;
        fail      = 1'b0;

        case (state_q)
            SEND_RST: begin
                if (tx_idle_i) begin
                    wr_ps2_d  = 1'b1;
                    tx_data_d = CMD_RST;
                    state_d   = WAIT_TX_RST;
                end
            end
            WAIT_TX_RST: begin
                if (tx_done_tick_i) state_d = ACK_RST;
                else if (timeout_hit) fail = 1'b1;
            end
            ACK_RST: begin
                if (rx_done_tick_i) begin
                    if (rx_data_i == RX_ACK) begin
                        fe_cnt_d = 2'd0;
                        state_d  = BAT;
                    end else if (rx_data_i == RX_RSND && fe_cnt_q != FE_LAST) begin
                        fe_cnt_d = fe_cnt_q + 2'd1;
                        state_d  = SEND_RST;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timeout_hit) begin
                    fail = 1'b1;
                end
            end
            BAT: begin
                if (rx_done_tick_i) begin
                    if (rx_data_i == RX_BAT) state_d = ID;
                    else fail = 1'b1;
                end else if (timeout_hit) begin
                    fail = 1'b1;
                end
            end
            ID: begin
                if (rx_done_tick_i) begin
                    if (rx_data_i == RX_ID) state_d = SEND_EN;
                    else fail = 1'b1;
                end else if (timeout_hit) begin
                    fail = 1'b1;
                end
            end
            SEND_EN: begin
                if (tx_idle_i) begin
                    wr_ps2_d  = 1'b1;
                    tx_data_d = CMD_EN;
                    state_d   = WAIT_TX_EN;
                end
            end
            WAIT_TX_EN: begin
                if (tx_done_tick_i) state_d = ACK_EN;
                else if (timeout_hit) fail = 1'b1;
            end
            ACK_EN: begin
                if (rx_done_tick_i) begin
                    if (rx_data_i == RX_ACK) begin
                        fe_cnt_d = 2'd0;
                        state_d  = STREAM;
                    end else if (rx_data_i == RX_RSND && fe_cnt_q != FE_LAST) begin
                        fe_cnt_d = fe_cnt_q + 2'd1;
                        state_d  = SEND_EN;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timeout_hit) begin
                    fail = 1'b1;
                end
            end
            STREAM: begin
                // A BAT byte mid-stream means the mouse was re-plugged.
                if (rx_done_tick_i && rx_data_i == RX_BAT) state_d = ID;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = SEND_RST;
            end
        endcase

        if (fail) begin
            fe_cnt_d = 2'd0;
            if (retries_q < RETRY_MAX) begin
                retries_d = retries_q + 2'd1;
                state_d   = SEND_RST;
            end else begin
                state_d   = ERROR;
            end
        end

        if (restart_i) begin
            state_d   = SEND_RST;
            wr_ps2_d  = 1'b0;
            tx_data_d = 8'h00;
            retries_d = 2'd0;
            fe_cnt_d  = 2'd0;
        end
    end

    always_comb begin
        if (!counting || rx_done_tick_i || (state_d != state_q) || restart_i) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        stream_en_d = (state_d == STREAM);
        init_err_d  = (state_d == ERROR);
        init_done_d = restart_i ? 1'b0 : (init_done_q || (state_d == STREAM));
    end

    assign wr_ps2_o    = wr_ps2_q;
    assign tx_data_o   = tx_data_q;
    assign stream_en_o = stream_en_q;
    assign init_done_o = init_done_q;
    assign init_err_o  = init_err_q;
    assign retries_o   = retries_q;

endmodule

// File: tb/tb_mouse_init_sequencer.sv
// tb/tb_mouse_init_sequencer.sv - directed bench for mouse_init_sequencer
module tb_mouse_init_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       tx_idle = 1'b1;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       wr_ps2;
    logic [7:0] tx_data;
    logic       stream_en;
    logic       init_done;
    logic       init_err;
    logic [1:0] retries;

    int n_cmp = 0;
    int n_fail = 0;
    int tx_cnt = 0;
    int base = 0;
    logic [7:0] tx_log[$];

    mouse_init_sequencer #(
        .TIMEOUT_CYC(1000),
        .MAX_RETRY  (3),
        .TO_W       (26)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .restart_i     (restart),
        .tx_idle_i     (tx_idle),
        .tx_done_tick_i(tx_done),
        .rx_done_tick_i(rx_done),
        .rx_data_i     (rx_data),
        .wr_ps2_o      (wr_ps2),
        .tx_data_o     (tx_data),
        .stream_en_o   (stream_en),
        .init_done_o   (init_done),
        .init_err_o    (init_err),
        .retries_o     (retries)
    );

    always #5 clk = ~clk;

    // Transmitter model: accepts a write strobe, stays busy, then pulses done.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_ps2 === 1'b1) begin
                tx_idle = 1'b0;
                tx_log.push_back(tx_data);
                repeat (4) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
                tx_idle = 1'b1;
                tx_cnt++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] get_tx(input int idx);
        if (tx_log.size() > base + idx) return tx_log[base + idx];
        return 8'hxx;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        base = tx_cnt;
        rst_n = 1'b1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        #1;
    endtask

    task automatic wait_tx(input int n, input string name);
        int budget = 3000;
        while (tx_cnt < base + n && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        n_cmp++;
        if (tx_cnt < base + n) begin
            n_fail++;
            $display("FAIL %s_tx_wait: got %0d commands, want %0d", name, tx_cnt - base, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({wr_ps2, tx_data, stream_en, init_done, init_err, retries} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr=%b tx=%h se=%b dn=%b er=%b rt=%0d, want all 0",
                     wr_ps2, tx_data, stream_en, init_done, init_err, retries);
        end
        base = tx_cnt;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        wait_tx(1, "nom_ff");
        n_cmp++;
        if (get_tx(0) !== 8'hFF) begin n_fail++; $display("FAIL nom_cmd0: got %h want FF", get_tx(0)); end
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        wait_tx(2, "nom_f4");
        n_cmp++;
        if (get_tx(1) !== 8'hF4) begin n_fail++; $display("FAIL nom_cmd1: got %h want F4", get_tx(1)); end
        n_cmp++;
        if (stream_en !== 1'b0) begin n_fail++; $display("FAIL nom_pre_stream: got %b want 0", stream_en); end
        rx_byte(8'hFA);
        n_cmp++;
        if (stream_en !== 1'b1 || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL nom_stream: got se=%b dn=%b want 1 1", stream_en, init_done);
        end
        n_cmp++;
        if (retries !== 2'd0) begin n_fail++; $display("FAIL nom_retries: got %0d want 0", retries); end
    endtask

    task automatic test_resend();
        do_reset();
        wait_tx(1, "rsnd_ff");
        rx_byte(8'hFE);
        wait_tx(2, "rsnd_ff2");
        n_cmp++;
        if (get_tx(1) !== 8'hFF) begin n_fail++; $display("FAIL rsnd_cmd1: got %h want FF", get_tx(1)); end
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        wait_tx(3, "rsnd_f4");
        rx_byte(8'hFA);
        n_cmp++;
        if (get_tx(2) !== 8'hF4 || stream_en !== 1'b1 || retries !== 2'd0 || tx_cnt - base != 3) begin
            n_fail++;
            $display("FAIL rsnd_final: got cmd=%h se=%b rt=%0d n=%0d want F4 1 0 3",
                     get_tx(2), stream_en, retries, tx_cnt - base);
        end
    endtask

    task automatic test_fe_limit();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            wait_tx(k, "fe_ff");
            rx_byte(8'hFE);
        end
        wait_tx(4, "fe_ff4");
        n_cmp++;
        if (retries !== 2'd0) begin n_fail++; $display("FAIL fe_three: got retries %0d want 0", retries); end
        rx_byte(8'hFE);
        n_cmp++;
        if (retries !== 2'd1) begin n_fail++; $display("FAIL fe_fourth: got retries %0d want 1", retries); end
        wait_tx(5, "fe_ff5");
        n_cmp++;
        if (get_tx(4) !== 8'hFF) begin n_fail++; $display("FAIL fe_resend: got %h want FF", get_tx(4)); end
    endtask

    task automatic test_silent();
        int n = 0;
        int budget = 100;
        do_reset();
        while (tx_done !== 1'b1 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        while (wr_ps2 !== 1'b1 && n < 1100) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (n != 1002) begin n_fail++; $display("FAIL silent_timeout_len: got %0d cycles want 1002", n); end
        budget = 4000;
        while (init_err !== 1'b1 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        n_cmp++;
        if (init_err !== 1'b1 || retries !== 2'd3 || tx_cnt - base != 4) begin
            n_fail++;
            $display("FAIL silent_error: got er=%b rt=%0d n=%0d want 1 3 4", init_err, retries, tx_cnt - base);
        end
        repeat (300) @(negedge clk);
        #1;
        n_cmp++;
        if (tx_cnt - base != 4 || init_err !== 1'b1 || stream_en !== 1'b0) begin
            n_fail++;
            $display("FAIL silent_absorb: got n=%0d er=%b se=%b want 4 1 0", tx_cnt - base, init_err, stream_en);
        end
    endtask

    task automatic test_wrong_id();
        do_reset();
        wait_tx(1, "wid_ff");
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h03);
        wait_tx(2, "wid_ff2");
        n_cmp++;
        if (get_tx(1) !== 8'hFF || retries !== 2'd1) begin
            n_fail++;
            $display("FAIL wid_retry: got cmd=%h rt=%0d want FF 1", get_tx(1), retries);
        end
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        wait_tx(3, "wid_f4");
        rx_byte(8'hFA);
        n_cmp++;
        if (get_tx(2) !== 8'hF4 || stream_en !== 1'b1 || retries !== 2'd1) begin
            n_fail++;
            $display("FAIL wid_stream: got cmd=%h se=%b rt=%0d want F4 1 1", get_tx(2), stream_en, retries);
        end
    endtask

    task automatic test_hotplug();
        rx_byte(8'h08);
        n_cmp++;
        if (stream_en !== 1'b1) begin n_fail++; $display("FAIL hp_other_byte: got se=%b want 1", stream_en); end
        rx_byte(8'hAA);
        n_cmp++;
        if (stream_en !== 1'b0 || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL hp_drop: got se=%b dn=%b want 0 1", stream_en, init_done);
        end
        rx_byte(8'h00);
        wait_tx(4, "hp_f4");
        n_cmp++;
        if (get_tx(3) !== 8'hF4) begin n_fail++; $display("FAIL hp_cmd: got %h want F4", get_tx(3)); end
        rx_byte(8'hFA);
        n_cmp++;
        if (stream_en !== 1'b1) begin n_fail++; $display("FAIL hp_resume: got se=%b want 1", stream_en); end
    endtask

    task automatic test_async_reset();
        rx_byte(8'hAA);
        rx_byte(8'h00);
        wait_tx(5, "ar_f4");
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({wr_ps2, tx_data, stream_en, init_done, init_err, retries} !== 14'h0) begin
            n_fail++;
            $display("FAIL ar_outputs: got wr=%b tx=%h se=%b dn=%b er=%b rt=%0d, want all 0",
                     wr_ps2, tx_data, stream_en, init_done, init_err, retries);
        end
        @(negedge clk);
        base = tx_cnt;
        rst_n = 1'b1;
        wait_tx(1, "ar_ff");
        n_cmp++;
        if (get_tx(0) !== 8'hFF) begin n_fail++; $display("FAIL ar_reissue: got %h want FF", get_tx(0)); end
    endtask

    task automatic test_restart();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            wait_tx(k, "rs_ff");
            rx_byte(8'h11);
        end
        n_cmp++;
        if (init_err !== 1'b1 || retries !== 2'd3) begin
            n_fail++;
            $display("FAIL rs_error: got er=%b rt=%0d want 1 3", init_err, retries);
        end
        @(negedge clk);
        restart = 1'b1;
        #1;
        n_cmp++;
        if (init_err !== 1'b1) begin n_fail++; $display("FAIL rs_not_yet: got er=%b want 1", init_err); end
        @(negedge clk);
        restart = 1'b0;
        #1;
        n_cmp++;
        if ({wr_ps2, tx_data, stream_en, init_done, init_err, retries} !== 14'h0) begin
            n_fail++;
            $display("FAIL rs_outputs: got wr=%b tx=%h se=%b dn=%b er=%b rt=%0d, want all 0",
                     wr_ps2, tx_data, stream_en, init_done, init_err, retries);
        end
        wait_tx(5, "rs_ff5");
        n_cmp++;
        if (get_tx(4) !== 8'hFF) begin n_fail++; $display("FAIL rs_reissue: got %h want FF", get_tx(4)); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_resend();
        test_fe_limit();
        test_silent();
        test_wrong_id();
        test_hotplug();
        test_async_reset();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
